// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTL, up to STEP bit positions per clock.
// A three-state FSM (IDLE/SHIFT/DONE) walks the captured operand toward the final value.
module shift_seq_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SAW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [SAW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int LEVELS = $clog2(STEP) + 1;
    localparam logic [SAW-1:0] STEP_W = SAW'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic             fill_q;
    logic [SAW-1:0]   rem;
    logic [SAW-1:0]   k;
    logic [SAW-1:0]   rem_next;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        k        = (rem > STEP_W) ? STEP_W : rem;
        rem_next = rem - k;
    end

    // One 2:1 mux level per bit of k; level i moves the word by 2**i positions.
    always_comb begin
        shifted = result;
        for (int i = 0; i < LEVELS; i++) begin
            if (k[i]) begin
                case (mode_q)
                    2'b00:   shifted = shifted << (2 ** i);
                    2'b01:   shifted = shifted >> (2 ** i);
                    2'b10:   shifted = (shifted >> (2 ** i)) |
                                       ({WIDTH{fill_q}} << (WIDTH - 2 ** i));
                    default: shifted = (shifted << (2 ** i)) |
                                       (shifted >> (WIDTH - 2 ** i));
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (shamt != '0) ? SHIFT : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                state_next = (rem_next == '0) ? DONE : SHIFT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are only captured when idle or finishing, so a start during SHIFT is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            rem    <= '0;
            mode_q <= 2'b00;
            fill_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        result <= a;
                        rem    <= shamt;
                        mode_q <= mode;
                        fill_q <= a[WIDTH-1];
                    end
                end
                SHIFT: begin
                    result <= shifted;
                    rem    <= rem_next;
                end
                default: begin
                    result <= result;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, power of 2, at least 4.
REQ-002 Parameter STEP, default 1: maximum bit positions shifted per cycle, power of 2, at most WIDTH/2.
REQ-003 Derived SAW = log2(WIDTH): shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE or DONE.
REQ-007 mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL.
REQ-008 a  input  WIDTH  operand.
REQ-009 shamt  input  SAW  shift amount, 0..WIDTH-1.
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 done  output  1  single-cycle pulse, high only in DONE.
REQ-012 result  output  WIDTH  shifted value, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 On a start accepted in IDLE or DONE, the block SHALL capture a into result and capture mode and shamt into internal registers (rem = shamt).
REQ-015 After an accepted start, the next state SHALL be SHIFT if shamt != 0, else DONE with result = a.
REQ-016 Each SHIFT cycle SHALL shift result by k = min(STEP, rem) positions and SHALL set rem = rem - k.
REQ-017 SLL SHALL fill vacated LSBs with 0.
REQ-018 SRL SHALL fill vacated MSBs with 0.
REQ-019 SRA SHALL fill vacated MSBs with the captured operand MSB.
REQ-020 ROTL SHALL re-enter bits shifted out of the MSB at the LSB.
REQ-021 When rem becomes 0 in SHIFT, the next state SHALL be DONE; otherwise the FSM SHALL remain in SHIFT.
REQ-022 Latency SHALL be max(1, ceil(shamt/STEP)) cycles from the start sampling edge to the edge on which done rises.
REQ-023 In DONE without start, the next state SHALL be IDLE.
REQ-024 A start in DONE SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-025 start while in SHIFT SHALL be ignored; captured operands and mode SHALL be unaffected.
REQ-026 Input changes on a, mode or shamt after capture SHALL NOT affect the operation in progress.
REQ-027 result SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-028 The per-cycle shift SHALL be built from log2(STEP)+1 cascaded 2:1 mux levels (shift-by-1, 2, 4, ...), each level selected from the bits of k.
REQ-029 busy and done SHALL never be high simultaneously.

Reset
REQ-030 Assertion of rst SHALL immediately force state = IDLE, result = 0, rem = 0, busy = 0 and done = 0, independent of clk.
REQ-031 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 WIDTH=32, STEP=1; SLL a=0x00000001, shamt=31 -> result 0x80000000; busy high for 31 cycles; done pulses once, 31 cycles after start.
REQ-034 STEP=1; SRA a=0x80000000, shamt=4 -> 0xF8000000; SRL with the same inputs -> 0x08000000; done after 4 cycles each.
REQ-035 STEP=4; ROTL a=0x80000001, shamt=5 -> 0x00000030 after 2 cycles (k = 4, then 1).
REQ-036 shamt=0, a=0xDEADBEEF, any mode -> busy never high; done 1 cycle after start; result 0xDEADBEEF.
REQ-037 Start SLL a=0x1, shamt=8; assert start again with a=0xFF during SHIFT -> final result 0x100; then start in the DONE cycle -> new operation begins with no IDLE cycle.
REQ-038 Assert rst at cycle 3 of a shamt=10 shift -> busy = done = result = 0 immediately; no done pulse; a fresh start after release completes correctly.
